t03_vga_timing: RTL and testbench
=================================

# t03_vga_timing

Raster timing generator and pixel output stage for the team_03 display path. Produces the horizontal/vertical pixel counters consumed by the colour-selection logic, then registers the 8-bit colour that logic returns together with aligned sync and blanking for the VGA pins. Default geometry is 800x600@60 (40 MHz pixel rate). There is one counter pair per design; all sprite, text and colour stages run off its counts.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, 1 = active-high sync pulses, 0 = active-low

Ports:
- clk  in  1  system clock; the only clock. All state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- Hcnt  out  11  current pixel column, 0..H_TOTAL-1.
- Vcnt  out  11  current line, 0..V_TOTAL-1.
- color_in  in  8  colour for (Hcnt, Vcnt), from colour-selection logic, combinational in the same cycle.
- color_out  out  8  registered pixel colour to the DAC/pins.
- hsync  out  1  registered horizontal sync, aligned to color_out.
- vsync  out  1  registered vertical sync, aligned to color_out.
- blank  out  1  registered, 1 when color_out is outside the active area.
- line_start  out  1  one-cycle pulse when Hcnt==0 is presented (unregistered decode of the counters).
- frame_start  out  1  one-cycle pulse when Hcnt==0 and Vcnt==0 are presented.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628). Both totals must be ≤ 2047. Non-conforming parameters are out of scope.
- Line order is active, front porch, sync, back porch. Active area is Hcnt<H_ACTIVE and Vcnt<V_ACTIVE.
- Pixel tick (pix_en): 1 every clock by default; see Configuration.
- On each pix_en:
  - If Hcnt==H_TOTAL-1, Hcnt←0. Otherwise Hcnt←Hcnt+1.
  - When Hcnt wraps, Vcnt←(Vcnt==V_TOTAL-1) ? 0 : Vcnt+1.
  - Vcnt changes only on a Hcnt wrap.
- Sync decode:
  - hsync is active when H_ACTIVE+H_FP ≤ Hcnt < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967.
  - vsync is active when V_ACTIVE+V_FP ≤ Vcnt < V_ACTIVE+V_FP+V_SYNC, i.e. 601..604.
  - Active level is SYNC_POL. The inactive level is ~SYNC_POL.
- Output register, updated on pix_en:
  - color_out ← active ? color_in : 8'h00.
  - blank ← ~active.
  - hsync and vsync ← their decodes.
  - All four come from the same Hcnt/Vcnt.
- frame_start implies line_start.

## Timing
- Reset values:
  - Hcnt=0, Vcnt=0, color_out=8'h00, blank=1.
  - hsync and vsync are inactive (~SYNC_POL).
  - The divider phase is 0.
  - line_start=1 and frame_start=1 follow from the counter values.
- Rst has priority over pix_en. Asserting rst mid-line restarts the frame at (0,0) on the next edge. There is no partial-line completion.
- Latency: color_out, hsync, vsync and blank lag the Hcnt/Vcnt that produced them by exactly one pixel tick. Their relative alignment is zero cycles.
- Wrap-around: at (1055,627) the next tick gives (0,0) with frame_start=1. At (1055,n<627) the next tick gives (0,n+1).
- The first active pixel emerges on color_out one tick after (0,0) is presented.
- Pixel (H_ACTIVE-1) is the last non-blank output. The tick presenting Hcnt=H_ACTIVE produces blank=1 on the following tick.

## Configuration
- Macro: T03_VGA_PIXEL_DIV2_EN.
- Defined: a 1-bit phase register toggles every clock and pix_en=phase.
  - Counters and output registers advance every second clock, for a 20 MHz pixel rate from a 40 MHz clk.
  - line_start and frame_start are gated with pix_en, so they pulse for one clock.
- Undefined: pix_en is constant 1 and no phase register exists.

## Test plan
- Reset release: hold rst 3 clocks, release. Hcnt=0, Vcnt=0, blank=1, color_out=00 and sync is inactive during reset. On the first edge after release, Hcnt=1.
- Line sweep with color_in tied to 8'hA5 and SYNC_POL=1:
  - hsync rises on the output one tick after Hcnt=840 is presented and lasts exactly 128 ticks.
  - blank=0 for exactly 800 consecutive ticks per line, with color_out=A5 during that span.
  - color_out=00 for the remaining 256 ticks.
- Frame sweep:
  - vsync is high for exactly 4×1056 ticks, starting at line 601.
  - frame_start pulses once per 1056×628 = 663168 ticks.
  - Vcnt never exceeds 627.
- Wrap corner: force the counters to (1055,627) via a run from reset. The next tick gives (0,0) and frame_start=1. (1055,5) goes to (0,6) with line_start=1 and frame_start=0.
- Mid-frame reset: assert rst at (412,300) for 1 clock. The next edge gives (0,0) and blank=1, and the sequence then repeats the reset-release scenario.
- With T03_VGA_PIXEL_DIV2_EN defined:
  - Hcnt increments every 2 clocks.
  - A full line takes 2112 clocks.
  - line_start is high for 1 clock per line.
  - Output alignment stays at one tick.

Source files
------------

// File: rtl/t03_vga_timing_if.sv
// t03_vga_timing_if: raster counters, colour return path and VGA pin bundle.
// master = timing generator, slave = colour-selection / pin side.
interface t03_vga_timing_if;
  logic [10:0] Hcnt;
  logic [10:0] Vcnt;
  logic [7:0]  color_in;
  logic [7:0]  color_out;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        line_start;
  logic        frame_start;

  modport master (
    output Hcnt, Vcnt, color_out,
    output hsync, vsync, blank,
    output line_start, frame_start,
    input  color_in
  );

  modport slave (
    input  Hcnt, Vcnt, color_out,
    input  hsync, vsync, blank,
    input  line_start, frame_start,
    output color_in
  );
endinterface

// File: rtl/t03_vga_timing.sv
// t03_vga_timing: raster counters plus registered colour/sync/blank output.
// Macro T03_VGA_PIXEL_DIV2_EN: pixel tick every second clock.
module t03_vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1
) (
  input  logic             clk,
  input  logic             rst,
  t03_vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SP     = (SYNC_POL != 0);

  logic        pix_en;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [7:0]  color_q, color_d;
  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        h_wrap;
  logic        active;
  logic        hs_on;
  logic        vs_on;

`ifdef T03_VGA_PIXEL_DIV2_EN
  logic phase_q;

  // Divider phase: tick on every second clock, starting one clock after reset.
  always_ff @(posedge clk) begin
    if (rst) phase_q <= 1'b0;
    else     phase_q <= ~phase_q;
  end

  assign pix_en = phase_q;
`else
  assign pix_en = 1'b1;
`endif

  // Next raster position; Vcnt only moves when Hcnt wraps.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    h_wrap = (hcnt_q == H_LAST);
    if (h_wrap) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
    end else begin
      hcnt_d = hcnt_q + 11'd1;
    end
  end

  // Pixel/sync decode of the position currently presented.
  always_comb begin
    active  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_on   = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    vs_on   = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    color_d = active ? vga.color_in : 8'h00;
    blank_d = ~active;
    hs_d    = hs_on ? SP : ~SP;
    vs_d    = vs_on ? SP : ~SP;
  end

  // Counters and output stage advance together on the pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      color_q <= 8'h00;
      blank_q <= 1'b1;
      hs_q    <= ~SP;
      vs_q    <= ~SP;
    end else if (pix_en) begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      color_q <= color_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign vga.Hcnt        = hcnt_q;
  assign vga.Vcnt        = vcnt_q;
  assign vga.color_out   = color_q;
  assign vga.blank       = blank_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.line_start  = pix_en & (hcnt_q == '0);
  assign vga.frame_start = pix_en & (hcnt_q == '0) & (vcnt_q == '0);

endmodule

// File: tb/tb_t03_vga_timing.sv
// tb_t03_vga_timing: table vectors, hand sequences, random sweep vs model.
// Uses a reduced 28x16 raster so full frames fit in a short run.
module tb_t03_vga_timing;

  localparam int HA = 16;
  localparam int HF = 3;
  localparam int HS = 5;
  localparam int HB = 4;
  localparam int VA = 10;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

`ifdef T03_VGA_PIXEL_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  t03_vga_timing_if vif ();

  t03_vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif.master)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // Reference model: tick count since reset, position derived arithmetically.
  int         m_t;
  int         m_ph;
  logic [7:0] m_col;
  logic       m_blank;
  logic       m_hs;
  logic       m_vs;

  task automatic m_step(input logic r, input logic [7:0] c);
    int  h, v;
    bit  tick;
    if (r) begin
      m_t = 0; m_ph = 0; m_col = 8'h00;
      m_blank = 1'b1; m_hs = 1'b0; m_vs = 1'b0;
    end else begin
      tick = (DIV == 1) || (m_ph == 1);
      m_ph = (DIV == 2) ? 1 - m_ph : 0;
      if (tick) begin
        h = m_t % HT;
        v = (m_t / HT) % VT;
        m_col   = (h < HA && v < VA) ? c : 8'h00;
        m_blank = !(h < HA && v < VA);
        m_hs    = (h >= HA + HF) && (h < HA + HF + HS);
        m_vs    = (v >= VA + VF) && (v < VA + VF + VS);
        m_t     = (m_t + 1) % (HT * VT);
      end
    end
  endtask

  task automatic chk(input string nm, input int a, input int e);
    ntot++;
    if (a == e) npass++;
    else $display("FAIL %s: got %0d, want %0d", nm, a, e);
  endtask

  // One clock: apply inputs, advance model on the edge, return at negedge.
  task automatic cyc(input logic r, input logic [7:0] c);
    rst = r;
    vif.color_in = c;
    @(posedge clk);
    m_step(r, c);
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    bit pe;
    int h, v;
    h  = m_t % HT;
    v  = (m_t / HT) % VT;
    pe = (DIV == 1) || (m_ph == 1);
    chk({tag, ".Hcnt"}, int'(vif.Hcnt), h);
    chk({tag, ".Vcnt"}, int'(vif.Vcnt), v);
    chk({tag, ".color"}, int'(vif.color_out), int'(m_col));
    chk({tag, ".blank"}, int'(vif.blank), int'(m_blank));
    chk({tag, ".hsync"}, int'(vif.hsync), int'(m_hs));
    chk({tag, ".vsync"}, int'(vif.vsync), int'(m_vs));
    chk({tag, ".line_start"}, int'(vif.line_start), int'(pe && h == 0));
    chk({tag, ".frame_start"}, int'(vif.frame_start),
        int'(pe && h == 0 && v == 0));
  endtask

  typedef struct {
    string      nm;
    int         n;
    logic [7:0] col;
    int         h;
    int         v;
    logic [7:0] ecol;
    logic       bl;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } vec_t;

  vec_t vt[13];

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    vif.color_in = 8'h00;
    // n ticks after reset release -> position, and outputs from tick n-1.
    vt[0]  = '{"rst",      0, 8'hA5,  0,  0, 8'h00, 1, 0, 0, 1, 1};
    vt[1]  = '{"first",    1, 8'hA5,  1,  0, 8'hA5, 0, 0, 0, 0, 0};
    vt[2]  = '{"lastact", 16, 8'h3C, 16,  0, 8'h3C, 0, 0, 0, 0, 0};
    vt[3]  = '{"firstbl", 17, 8'h3C, 17,  0, 8'h00, 1, 0, 0, 0, 0};
    vt[4]  = '{"hs_on",   20, 8'hA5, 20,  0, 8'h00, 1, 1, 0, 0, 0};
    vt[5]  = '{"hs_last", 24, 8'hA5, 24,  0, 8'h00, 1, 1, 0, 0, 0};
    vt[6]  = '{"hs_off",  25, 8'hA5, 25,  0, 8'h00, 1, 0, 0, 0, 0};
    vt[7]  = '{"line1",   28, 8'h81,  0,  1, 8'h00, 1, 0, 0, 1, 0};
    vt[8]  = '{"vs_on",  309, 8'h81,  1, 11, 8'h00, 1, 0, 1, 0, 0};
    vt[9]  = '{"vs_mid", 336, 8'h81,  0, 12, 8'h00, 1, 0, 1, 1, 0};
    vt[10] = '{"vs_off", 365, 8'h81,  1, 13, 8'h00, 1, 0, 0, 0, 0};
    vt[11] = '{"frm_end",447, 8'h81, 27, 15, 8'h00, 1, 0, 0, 0, 0};
    vt[12] = '{"wrap",   448, 8'h81,  0,  0, 8'h00, 1, 0, 0, 1, 1};

    @(negedge clk);
    for (int k = 0; k < 13; k++) begin
      do_reset();
      for (int i = 0; i < vt[k].n * DIV; i++) cyc(1'b0, vt[k].col);
      chk({vt[k].nm, ".Hcnt"}, int'(vif.Hcnt), vt[k].h);
      chk({vt[k].nm, ".Vcnt"}, int'(vif.Vcnt), vt[k].v);
      chk({vt[k].nm, ".color"}, int'(vif.color_out), int'(vt[k].ecol));
      chk({vt[k].nm, ".blank"}, int'(vif.blank), int'(vt[k].bl));
      chk({vt[k].nm, ".hsync"}, int'(vif.hsync), int'(vt[k].hs));
      chk({vt[k].nm, ".vsync"}, int'(vif.vsync), int'(vt[k].vs));
`ifndef T03_VGA_PIXEL_DIV2_EN
      chk({vt[k].nm, ".line_start"}, int'(vif.line_start), int'(vt[k].ls));
      chk({vt[k].nm, ".frame_start"}, int'(vif.frame_start), int'(vt[k].fs));
`endif
    end

    // Line wrap mid-frame: (27,5) -> (0,6).
    do_reset();
    for (int i = 0; i < (5 * HT + HT - 1) * DIV; i++) cyc(1'b0, 8'h11);
    chk("pre_wrap.Hcnt", int'(vif.Hcnt), HT - 1);
    chk("pre_wrap.Vcnt", int'(vif.Vcnt), 5);
    for (int i = 0; i < DIV; i++) cyc(1'b0, 8'h11);
    chk("wrap5.Hcnt", int'(vif.Hcnt), 0);
    chk("wrap5.Vcnt", int'(vif.Vcnt), 6);
    chk("wrap5.frame_start", int'(vif.frame_start), 0);

    // Mid-frame reset at (12,5) for one clock.
    do_reset();
    for (int i = 0; i < (5 * HT + 12) * DIV; i++) cyc(1'b0, 8'h5A);
    chk("midrst_pre.Hcnt", int'(vif.Hcnt), 12);
    chk("midrst_pre.blank", int'(vif.blank), 0);
    cyc(1'b1, 8'h5A);
    chk("midrst.Hcnt", int'(vif.Hcnt), 0);
    chk("midrst.Vcnt", int'(vif.Vcnt), 0);
    chk("midrst.blank", int'(vif.blank), 1);
    chk("midrst.color", int'(vif.color_out), 0);
    for (int i = 0; i < DIV; i++) cyc(1'b0, 8'h5A);
    chk("midrst_rel.Hcnt", int'(vif.Hcnt), 1);
    chk("midrst_rel.color", int'(vif.color_out), 8'h5A);

    // Random colour and sparse resets over several frames vs model.
    do_reset();
    for (int i = 0; i < 3 * HT * VT * DIV + 50; i++) begin
      cyc($urandom_range(0, 599) == 0, 8'($urandom));
      chk_model("rand");
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
